// File: rtl/execute_pkg.sv
// Shared definitions for the multi-cycle execute stage.
//   - ALU opcode encodings (4-bit; codes 14 and 15 are unused and yield 0)
//   - forwarding-select encodings for the A/B operand muxes
//   - FSM state type and state constants
package execute_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SEQ  = 4'd10;
  localparam logic [3:0] OP_SNE  = 4'd11;
  localparam logic [3:0] OP_LHI  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  // Select value 3 is reserved and falls through to the register value.
  localparam logic [1:0] FWD_REG     = 2'd0;
  localparam logic [1:0] FWD_EXE_MEM = 2'd1;
  localparam logic [1:0] FWD_MEM_WB  = 2'd2;

  typedef logic [0:0] exe_state_t;
  localparam exe_state_t ST_IDLE = 1'b0;
  localparam exe_state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/execute_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per enabled cycle.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (aborts any multiply)
//   en              advance enable; low freezes all internal state
//   start           load a/b and begin (honoured only when not busy)
//   a, b            operands, captured on start
//   busy            a multiply is in progress
//   done            high in the final iteration cycle; result is valid then
//   result          low DATA_WIDTH bits of a*b (meaningful while done=1)
module execute_mul_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [CW-1:0]         count;

  // Accumulator value after the current iteration; on the last iteration
  // this is the finished product, handed out combinationally so the caller
  // can register it on the same edge the multiplier goes idle.
  assign result = acc + (mplier[0] ? mcand : '0);
  assign done   = busy && (count == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (en) begin
      if (start && !busy) begin
        busy   <= 1'b1;
        count  <= CW'(DATA_WIDTH);
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
      end else if (busy) begin
        acc    <= result;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
        if (count == CW'(1)) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage with operand forwarding, single-cycle ALU and an iterative
// multiplier.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   valid_in, alu_opcode_in,    operation request and opcode
//   alu_src_in                  1 selects constant_in as operand B
//   fwd_a_sel_in, fwd_b_sel_in  0 reg, 1 exe_mem_data_in, 2 mem_wb_data_in, 3 = 0
//   data_alu_a_in/b_in, constant_in, exe_mem_data_in, mem_wb_data_in  data
//   w_reg_*_in, mem_data_wr_en_in, write_back_mux_sel_in,
//   branch_inst_in, jmp_inst_in  sideband carried with the operation
//   stall_in                    downstream hold: freezes outputs and FSM
//   stall_out                   busy / held; upstream must hold its inputs
//   valid_out, alu_data_out, alu_b_data_out, branch_taken_out, registered
//   sideband copies             results
//   fsm_state                   current FSM state (debug)
//
// Handshake: an operation is accepted on a rising edge where valid_in=1,
// stall_in=0 and stall_out=0. Upstream keeps inputs stable while
// stall_out=1; downstream sees a result while valid_out=1 and holds it
// in place by asserting stall_in.
import execute_pkg::*;

module execute_stage_mc #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [ALU_OP_WIDTH-1:0]   alu_opcode_in,
  input  logic                      alu_src_in,
  input  logic [1:0]                fwd_a_sel_in,
  input  logic [1:0]                fwd_b_sel_in,
  input  logic [DATA_WIDTH-1:0]     data_alu_a_in,
  input  logic [DATA_WIDTH-1:0]     data_alu_b_in,
  input  logic [DATA_WIDTH-1:0]     constant_in,
  input  logic [DATA_WIDTH-1:0]     exe_mem_data_in,
  input  logic [DATA_WIDTH-1:0]     mem_wb_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
  input  logic                      w_reg_wr_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic                      write_back_mux_sel_in,
  input  logic                      branch_inst_in,
  input  logic                      jmp_inst_in,
  input  logic                      stall_in,
  output logic                      stall_out,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     alu_data_out,
  output logic [DATA_WIDTH-1:0]     alu_b_data_out,
  output logic                      branch_taken_out,
  output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_out,
  output logic                      w_reg_wr_en_out,
  output logic                      mem_data_wr_en_out,
  output logic                      write_back_mux_sel_out,
  output logic                      jmp_inst_out,
  output exe_state_t                fsm_state
);

  localparam int SHW = $clog2(DATA_WIDTH);

  function automatic logic [DATA_WIDTH-1:0] fwd_mux(
    input logic [1:0]            sel,
    input logic [DATA_WIDTH-1:0] reg_val,
    input logic [DATA_WIDTH-1:0] em_val,
    input logic [DATA_WIDTH-1:0] wb_val
  );
    case (sel)
      FWD_EXE_MEM: return em_val;
      FWD_MEM_WB:  return wb_val;
      default:     return reg_val;
    endcase
  endfunction

  exe_state_t            state;
  logic [DATA_WIDTH-1:0] fwd_b, op_a, op_b, alu_result, mul_result;
  logic [SHW-1:0]        shamt;
  logic                  is_mul, accept, mul_busy, mul_done;
  // Gated sideband for an in-flight multiply, released with its result.
  logic                  pend_wr_en, pend_mem_wr, pend_branch, pend_jmp;

  assign fwd_b  = fwd_mux(fwd_b_sel_in, data_alu_b_in, exe_mem_data_in, mem_wb_data_in);
  assign op_a   = fwd_mux(fwd_a_sel_in, data_alu_a_in, exe_mem_data_in, mem_wb_data_in);
  assign op_b   = alu_src_in ? constant_in : fwd_b;
  assign shamt  = op_b[SHW-1:0];
  assign is_mul = (alu_opcode_in == ALU_OP_WIDTH'(OP_MUL));
  assign accept = valid_in && !stall_in && (state == ST_IDLE) && !mul_busy;

  // Held result under stall_in also counts as busy towards upstream.
  assign stall_out = (state == ST_MUL) || (stall_in && valid_out);
  assign fsm_state = state;

  always_comb begin
    alu_result = '0;
    case (alu_opcode_in)
      ALU_OP_WIDTH'(OP_ADD):  alu_result = op_a + op_b;
      ALU_OP_WIDTH'(OP_SUB):  alu_result = op_a - op_b;
      ALU_OP_WIDTH'(OP_AND):  alu_result = op_a & op_b;
      ALU_OP_WIDTH'(OP_OR):   alu_result = op_a | op_b;
      ALU_OP_WIDTH'(OP_XOR):  alu_result = op_a ^ op_b;
      ALU_OP_WIDTH'(OP_SLL):  alu_result = op_a << shamt;
      ALU_OP_WIDTH'(OP_SRL):  alu_result = op_a >> shamt;
      ALU_OP_WIDTH'(OP_SRA):  alu_result = $unsigned($signed(op_a) >>> shamt);
      ALU_OP_WIDTH'(OP_SLT):  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_OP_WIDTH'(OP_SLTU): alu_result = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_OP_WIDTH'(OP_SEQ):  alu_result = {{(DATA_WIDTH-1){1'b0}}, (op_a == op_b)};
      ALU_OP_WIDTH'(OP_SNE):  alu_result = {{(DATA_WIDTH-1){1'b0}}, (op_a != op_b)};
      ALU_OP_WIDTH'(OP_LHI):  alu_result = op_b << (DATA_WIDTH / 2);
      default:                alu_result = '0;
    endcase
  end

  execute_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (!stall_in),
    .start  (accept && is_mul),
    .a      (op_a),
    .b      (op_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                  <= ST_IDLE;
      valid_out              <= 1'b0;
      alu_data_out           <= '0;
      alu_b_data_out         <= '0;
      branch_taken_out       <= 1'b0;
      w_reg_addr_out         <= '0;
      w_reg_wr_en_out        <= 1'b0;
      mem_data_wr_en_out     <= 1'b0;
      write_back_mux_sel_out <= 1'b0;
      jmp_inst_out           <= 1'b0;
      pend_wr_en             <= 1'b0;
      pend_mem_wr            <= 1'b0;
      pend_branch            <= 1'b0;
      pend_jmp               <= 1'b0;
    end else if (!stall_in) begin
      if (state == ST_IDLE) begin
        valid_out <= accept && !is_mul;
        if (accept) begin
          // Ungated sideband is copied immediately, even for a multiply.
          alu_b_data_out         <= fwd_b;
          w_reg_addr_out         <= w_reg_addr_in;
          write_back_mux_sel_out <= write_back_mux_sel_in;
        end
        if (accept && !is_mul) begin
          alu_data_out       <= alu_result;
          w_reg_wr_en_out    <= w_reg_wr_en_in;
          mem_data_wr_en_out <= mem_data_wr_en_in;
          jmp_inst_out       <= jmp_inst_in;
          branch_taken_out   <= branch_inst_in && (alu_result == '0);
        end else begin
          w_reg_wr_en_out    <= 1'b0;
          mem_data_wr_en_out <= 1'b0;
          jmp_inst_out       <= 1'b0;
          branch_taken_out   <= 1'b0;
        end
        if (accept && is_mul) begin
          state       <= ST_MUL;
          pend_wr_en  <= w_reg_wr_en_in;
          pend_mem_wr <= mem_data_wr_en_in;
          pend_branch <= branch_inst_in;
          pend_jmp    <= jmp_inst_in;
        end
      end else if (mul_done) begin
        state              <= ST_IDLE;
        valid_out          <= 1'b1;
        alu_data_out       <= mul_result;
        w_reg_wr_en_out    <= pend_wr_en;
        mem_data_wr_en_out <= pend_mem_wr;
        jmp_inst_out       <= pend_jmp;
        branch_taken_out   <= pend_branch && (mul_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
module tb_execute_stage_mc;
  import execute_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 4;

  logic          clk, rst_n, valid_in, alu_src_in, stall_in;
  logic [OW-1:0] alu_opcode_in;
  logic [1:0]    fwd_a_sel_in, fwd_b_sel_in;
  logic [DW-1:0] data_alu_a_in, data_alu_b_in, constant_in, exe_mem_data_in, mem_wb_data_in;
  logic [AW-1:0] w_reg_addr_in, w_reg_addr_out;
  logic          w_reg_wr_en_in, mem_data_wr_en_in, write_back_mux_sel_in, branch_inst_in, jmp_inst_in;
  logic          stall_out, valid_out, branch_taken_out;
  logic [DW-1:0] alu_data_out, alu_b_data_out;
  logic          w_reg_wr_en_out, mem_data_wr_en_out, write_back_mux_sel_out, jmp_inst_out;
  exe_state_t    fsm_state;

  execute_stage_mc #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .ALU_OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_opcode_in(alu_opcode_in),
    .alu_src_in(alu_src_in), .fwd_a_sel_in(fwd_a_sel_in), .fwd_b_sel_in(fwd_b_sel_in),
    .data_alu_a_in(data_alu_a_in), .data_alu_b_in(data_alu_b_in), .constant_in(constant_in),
    .exe_mem_data_in(exe_mem_data_in), .mem_wb_data_in(mem_wb_data_in),
    .w_reg_addr_in(w_reg_addr_in), .w_reg_wr_en_in(w_reg_wr_en_in),
    .mem_data_wr_en_in(mem_data_wr_en_in), .write_back_mux_sel_in(write_back_mux_sel_in),
    .branch_inst_in(branch_inst_in), .jmp_inst_in(jmp_inst_in), .stall_in(stall_in),
    .stall_out(stall_out), .valid_out(valid_out), .alu_data_out(alu_data_out),
    .alu_b_data_out(alu_b_data_out), .branch_taken_out(branch_taken_out),
    .w_reg_addr_out(w_reg_addr_out), .w_reg_wr_en_out(w_reg_wr_en_out),
    .mem_data_wr_en_out(mem_data_wr_en_out), .write_back_mux_sel_out(write_back_mux_sel_out),
    .jmp_inst_out(jmp_inst_out), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  logic [3:0]    f_op [10] = '{OP_SUB, OP_SRA, OP_SLL, OP_LHI, OP_SLT, OP_SLTU, OP_SEQ, OP_SNE, 4'd14, OP_ADD};
  logic [DW-1:0] f_a  [10] = '{32'h0, 32'h80000000, 32'h1, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h3, 32'hFFFFFFFF};
  logic [DW-1:0] f_b  [10] = '{32'h1, 32'd33, 32'd36, 32'h1234ABCD, 32'h1, 32'h1, 32'h5, 32'h5, 32'h4, 32'h2};
  logic [DW-1:0] f_exp[10] = '{32'hFFFFFFFF, 32'hC0000000, 32'h10, 32'hABCD0000, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1};

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_fwd(input logic [1:0] sel, input logic [DW-1:0] r, em, mw);
    if (sel == 2'd1) return em;
    if (sel == 2'd2) return mw;
    return r;
  endfunction

  function automatic logic [DW-1:0] model_alu(input logic [3:0] op, input logic [DW-1:0] a, b);
    logic [DW-1:0] all1, r;
    int sh;
    all1 = '1;
    sh = int'(b[4:0]);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA: begin
        r = a >> sh;
        if (a[DW-1]) r = r | ~(all1 >> sh);
        return r;
      end
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SEQ:  return (a == b) ? 32'd1 : 32'd0;
      OP_SNE:  return (a != b) ? 32'd1 : 32'd0;
      OP_LHI:  return {b[15:0], 16'h0000};
      OP_MUL:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid_in = 1'b0; alu_opcode_in = '0; alu_src_in = 1'b0;
    fwd_a_sel_in = 2'd0; fwd_b_sel_in = 2'd0;
    data_alu_a_in = '0; data_alu_b_in = '0; constant_in = '0;
    exe_mem_data_in = '0; mem_wb_data_in = '0;
    w_reg_addr_in = '0; w_reg_wr_en_in = 1'b0; mem_data_wr_en_in = 1'b0;
    write_back_mux_sel_in = 1'b0; branch_inst_in = 1'b0; jmp_inst_in = 1'b0;
    stall_in = 1'b0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [1:0] fa, fb, input logic src,
                          input logic [DW-1:0] ra, rb, k, em, mw);
    valid_in = 1'b1; alu_opcode_in = op; alu_src_in = src;
    fwd_a_sel_in = fa; fwd_b_sel_in = fb;
    data_alu_a_in = ra; data_alu_b_in = rb; constant_in = k;
    exe_mem_data_in = em; mem_wb_data_in = mw;
    w_reg_wr_en_in = 1'b1; branch_inst_in = 1'b0; jmp_inst_in = 1'b0;
  endtask

  task automatic scramble_inputs();
    valid_in = 1'b1;
    alu_opcode_in = 4'($urandom_range(0, 15));
    alu_src_in = 1'($urandom_range(0, 1));
    fwd_a_sel_in = 2'($urandom_range(0, 3));
    fwd_b_sel_in = 2'($urandom_range(0, 3));
    data_alu_a_in = $urandom; data_alu_b_in = $urandom; constant_in = $urandom;
    exe_mem_data_in = $urandom; mem_wb_data_in = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_op(OP_ADD, 2'd0, 2'd0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0);
    step(); step();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
    checks++; if (alu_data_out !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", alu_data_out); end
    checks++; if (w_reg_wr_en_out !== 1'b0 || branch_taken_out !== 1'b0) begin
      failures++; $display("FAIL reset_gated: wr_en %b branch %b expected 0", w_reg_wr_en_out, branch_taken_out); end
    checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %b expected IDLE", fsm_state); end
    drive_idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_fwd();
    logic [DW-1:0] exp;
    drive_op(OP_ADD, 2'd1, 2'd0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd5, 32'd200);
    w_reg_addr_in = 5'd9;
    exp_q.push_back(32'd12);
    step();
    drive_idle();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL add_valid: got %b expected 1", valid_out); end
    exp = exp_q.pop_front();
    checks++; if (alu_data_out !== exp) begin failures++; $display("FAIL add_data: got %h expected %h", alu_data_out, exp); end
    checks++; if (w_reg_addr_out !== 5'd9 || w_reg_wr_en_out !== 1'b1) begin
      failures++; $display("FAIL add_sideband: addr %0d wr_en %b expected 9 1", w_reg_addr_out, w_reg_wr_en_out); end
    step();
    checks++; if (valid_out !== 1'b0 || w_reg_wr_en_out !== 1'b0) begin
      failures++; $display("FAIL idle_clear: valid %b wr_en %b expected 0 0", valid_out, w_reg_wr_en_out); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]    op;
    logic [1:0]    fa, fb;
    logic          src;
    logic [DW-1:0] ra, rb, k, em, mw, a, bf, exp;
    for (int i = 0; i < 26; i++) begin
      if (i < 10) begin
        op = f_op[i]; fa = 2'd0; fb = 2'd0; src = 1'b0;
        ra = f_a[i]; rb = f_b[i]; k = $urandom; em = $urandom; mw = $urandom;
        bf = rb;
        exp_q.push_back(f_exp[i]);
      end else begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_MUL) op = OP_XOR;
        fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
        src = 1'($urandom_range(0, 1));
        ra = $urandom; rb = $urandom; k = $urandom; em = $urandom; mw = $urandom;
        if (i % 4 == 0) rb = ra;
        a  = model_fwd(fa, ra, em, mw);
        bf = model_fwd(fb, rb, em, mw);
        exp_q.push_back(model_alu(op, a, src ? k : bf));
      end
      drive_op(op, fa, fb, src, ra, rb, k, em, mw);
      step();
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL alu_valid[%0d]: got %b expected 1", i, valid_out); end
      exp = exp_q.pop_front();
      checks++; if (alu_data_out !== exp) begin
        failures++; $display("FAIL alu_data[%0d] op %0d: got %h expected %h", i, op, alu_data_out, exp); end
      checks++; if (alu_b_data_out !== bf) begin
        failures++; $display("FAIL alu_b_fwd[%0d]: got %h expected %h", i, alu_b_data_out, bf); end
    end
    drive_idle();
    step();
  endtask

  // MUL whose operands are scrambled mid-op; optional 3-cycle stall_in at cnt 5..7.
  task automatic run_mul(input string name, input logic [1:0] fa, input logic src,
                         input logic [DW-1:0] ra, rb, k, mw, input logic br,
                         input bit do_stall, input int exp_cycles, input logic exp_br);
    int cnt, bad;
    logic [DW-1:0] exp;
    drive_op(OP_MUL, fa, 2'd0, src, ra, rb, k, 32'd0, mw);
    branch_inst_in = br;
    exp_q.push_back(model_alu(OP_MUL, model_fwd(fa, ra, 32'd0, mw), src ? k : rb));
    step();
    checks++; if (stall_out !== 1'b1 || fsm_state !== ST_MUL) begin
      failures++; $display("FAIL %s_start: stall %b state %b expected 1 MUL", name, stall_out, fsm_state); end
    cnt = 0; bad = 0;
    while (stall_out === 1'b1 && cnt < 200) begin
      if (valid_out !== 1'b0) bad++;
      scramble_inputs();
      stall_in = do_stall && (cnt >= 5) && (cnt <= 7);
      cnt++;
      step();
    end
    drive_idle();
    checks++; if (cnt !== exp_cycles) begin
      failures++; $display("FAIL %s_latency: got %0d stall cycles expected %0d", name, cnt, exp_cycles); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL %s_early_valid: got %0d cycles expected 0", name, bad); end
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL %s_valid: got %b expected 1", name, valid_out); end
    exp = exp_q.pop_front();
    checks++; if (alu_data_out !== exp) begin failures++; $display("FAIL %s_data: got %h expected %h", name, alu_data_out, exp); end
    checks++; if (branch_taken_out !== exp_br) begin
      failures++; $display("FAIL %s_branch: got %b expected %b", name, branch_taken_out, exp_br); end
  endtask

  task automatic test_mul();
    run_mul("mul_6x7", 2'd2, 1'b1, 32'd0, 32'd0, 32'd7, 32'd6, 1'b0, 1'b0, 32, 1'b0);
    step();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mul_after: got %b expected 0", valid_out); end
    run_mul("mul_rand", 2'd0, 1'b0, $urandom, $urandom, 32'd0, 32'd0, 1'b0, 1'b0, 32, 1'b0);
    step();
  endtask

  task automatic test_mul_stall();
    logic [DW-1:0] held;
    run_mul("mul_stall", 2'd0, 1'b0, 32'hDEADBEEF, 32'h00012345, 32'd0, 32'd0, 1'b0, 1'b1, 35, 1'b0);
    held = alu_data_out;
    // hold the completed result with a competing request offered
    drive_op(OP_ADD, 2'd0, 2'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0);
    stall_in = 1'b1;
    step(); step();
    checks++; if (valid_out !== 1'b1 || stall_out !== 1'b1) begin
      failures++; $display("FAIL hold_flags: valid %b stall %b expected 1 1", valid_out, stall_out); end
    checks++; if (alu_data_out !== held) begin failures++; $display("FAIL hold_data: got %h expected %h", alu_data_out, held); end
    drive_idle();
    step();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL hold_release: got %b expected 0", valid_out); end
  endtask

  task automatic test_reset_mid_mul();
    int bad;
    drive_op(OP_MUL, 2'd0, 2'd0, 1'b0, 32'h1234, 32'h5678, 32'd0, 32'd0, 32'd0);
    step();
    drive_idle();
    for (int i = 1; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (stall_out !== 1'b0 || valid_out !== 1'b0) begin
      failures++; $display("FAIL abort_flags: stall %b valid %b expected 0 0", stall_out, valid_out); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_out !== 1'b0 || stall_out !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL abort_no_result: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_branch();
    logic [DW-1:0] exp;
    drive_op(OP_SUB, 2'd0, 2'd0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 32'd0);
    branch_inst_in = 1'b1; jmp_inst_in = 1'b1;
    exp_q.push_back(32'd0);
    step();
    exp = exp_q.pop_front();
    checks++; if (alu_data_out !== exp || branch_taken_out !== 1'b1 || jmp_inst_out !== 1'b1) begin
      failures++; $display("FAIL beq_taken: data %h branch %b jmp %b expected %h 1 1", alu_data_out, branch_taken_out, jmp_inst_out, exp); end
    valid_in = 1'b0;
    step();
    checks++; if (branch_taken_out !== 1'b0 || jmp_inst_out !== 1'b0 || valid_out !== 1'b0) begin
      failures++; $display("FAIL beq_invalid: branch %b jmp %b valid %b expected 0 0 0", branch_taken_out, jmp_inst_out, valid_out); end
    drive_op(OP_SUB, 2'd0, 2'd0, 1'b0, 32'd9, 32'd4, 32'd0, 32'd0, 32'd0);
    branch_inst_in = 1'b1;
    exp_q.push_back(32'd5);
    step();
    exp = exp_q.pop_front();
    checks++; if (alu_data_out !== exp || branch_taken_out !== 1'b0) begin
      failures++; $display("FAIL bne_not_taken: data %h branch %b expected %h 0", alu_data_out, branch_taken_out, exp); end
    run_mul("mul_zero_br", 2'd0, 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, 32, 1'b1);
    drive_idle();
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    test_add_fwd();
    test_alu_ops();
    test_mul();
    test_mul_stall();
    test_reset_mid_mul();
    test_branch();
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage_mc.md
EXECUTE_STAGE_MC -- requirements
Module: execute_stage_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width; SHALL be a power of two, at least 8.
REQ-002 Parameter REG_ADDR_WIDTH, default 5: width of the destination register address.
REQ-003 Parameter ALU_OP_WIDTH, default 4: width of the ALU opcode.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Inputs valid_in (1), alu_opcode_in (ALU_OP_WIDTH), alu_src_in (1; 1 selects constant_in as operand B).
REQ-007 Forwarding inputs fwd_a_sel_in and fwd_b_sel_in (2 each): 0 selects the register value, 1 selects exe_mem_data_in, 2 selects mem_wb_data_in, 3 is reserved and behaves as 0.
REQ-008 Data inputs data_alu_a_in, data_alu_b_in, constant_in, exe_mem_data_in, mem_wb_data_in, each DATA_WIDTH.
REQ-009 Sideband inputs w_reg_addr_in (REG_ADDR_WIDTH), w_reg_wr_en_in, mem_data_wr_en_in, write_back_mux_sel_in, branch_inst_in, jmp_inst_in (1 each).
REQ-010 Input stall_in (1): downstream hold request.
REQ-011 Output stall_out (1): multiply is busy; upstream SHALL hold its inputs while this is high.
REQ-012 Outputs valid_out (1), alu_data_out (DATA_WIDTH), alu_b_data_out (DATA_WIDTH; forwarded B, for stores), branch_taken_out (1).
REQ-013 Outputs w_reg_addr_out, w_reg_wr_en_out, mem_data_wr_en_out, write_back_mux_sel_out, jmp_inst_out: registered copies of the matching inputs.

Function
REQ-014 Operand A SHALL be the forwarded A; operand B SHALL be constant_in if alu_src_in is 1, otherwise the forwarded B.
REQ-015 Opcodes: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, SEQ, SNE, LHI, MUL; unused codes SHALL yield a result of 0.
REQ-016 Arithmetic SHALL wrap modulo 2^DATA_WIDTH.
REQ-017 Shift amount SHALL be B[$clog2(DATA_WIDTH)-1:0]; the upper bits of B are ignored.
REQ-018 Comparison ops (SLT, SLTU, SEQ, SNE) SHALL return 0 or 1, zero-extended to DATA_WIDTH.
REQ-019 LHI SHALL return B shifted left by DATA_WIDTH/2.
REQ-020 MUL SHALL return the low DATA_WIDTH bits of A*B.
REQ-021 Non-MUL ops: with valid_in=1, stall_in=0 and stall_out=0, all outputs SHALL update on the next edge with valid_out=1 (latency 1).
REQ-022 FSM states IDLE and MUL.
- IDLE to MUL: accepted valid_in with opcode MUL; A and B are captured.
- MUL: shift-add, one bit per cycle, for DATA_WIDTH cycles; stall_out=1 throughout.
- MUL to IDLE: on completion the result is registered and valid_out=1.
REQ-023 MUL latency SHALL be DATA_WIDTH+1 cycles from acceptance to valid_out.
REQ-024 Captured MUL operands SHALL NOT be affected by changes to the forwarding or data inputs during the MUL state.
REQ-025 valid_in SHALL be ignored while stall_out=1.
REQ-026 stall_in=1 SHALL freeze all output registers and the FSM, including a MUL in progress.
REQ-027 stall_out SHALL be high while stall_in holds the block, whether in MUL or holding a completed result.
REQ-028 No new operation SHALL be accepted while stall_in=1.
REQ-029 A cycle with no accepted operation and stall_in=0 SHALL clear valid_out.
REQ-030 w_reg_wr_en_out, mem_data_wr_en_out, branch_taken_out and jmp_inst_out SHALL be 0 whenever valid_out=0.
REQ-031 branch_taken_out SHALL equal branch_inst_in AND (result == 0), registered alongside the result.

Reset
REQ-032 While rst_n=0 at an edge, the FSM SHALL go to IDLE and every output register SHALL clear to 0 (including valid_out and stall_out).
REQ-033 A reset during the MUL state SHALL abort the multiply with no result produced.

Structure
REQ-034 A shared package execute_pkg SHALL hold the ALU opcode encodings, the forwarding-select encodings and the FSM state type.
REQ-035 The iterative multiplier SHALL be a sub-module, execute_mul_iter, with a start/busy/done handshake; the ALU and forwarding logic stay in the top module.

Verification
REQ-036 ADD, fwd_a_sel=1, exe_mem_data=5, B=7 -> next cycle alu_data_out=12, valid_out=1.
REQ-037 SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000 by B=33 -> 0xC0000000 (shift amount 1).
REQ-038 MUL 6*7 -> stall_out high for 32 cycles, then alu_data_out=42; operand inputs toggled mid-op do not change the result.
REQ-039 stall_in held 3 cycles during MUL -> result appears 3 cycles later than REQ-023, value unchanged.
REQ-040 rst_n low at the 10th MUL cycle -> next cycle stall_out=0 and valid_out=0, with no result produced.
REQ-041 BEQ-style SUB with equal operands and branch_inst_in=1 -> branch_taken_out=1; with valid_in=0 -> branch_taken_out=0.
